// File: rtl/pcs_rx_align_ctrl_pkg.sv
// Shared PCS receive-alignment types and default tuning constants.
package pcs_rx_align_ctrl_pkg;

  // Default cycles allowed in DESKEW before a restart
  localparam int unsigned DESKEW_TIMEOUT_DEF  = 2048;
  // Default count of consecutive misaligned AM events that drop alignment
  localparam int unsigned AM_MISMATCH_MAX_DEF = 3;

  // Alignment sequencer states
  typedef enum logic [1:0] {
    WAIT_BS = 2'd0,
    WAIT_AM = 2'd1,
    DESKEW  = 2'd2,
    ALIGNED = 2'd3
  } pcs_align_state_e;

endpackage : pcs_rx_align_ctrl_pkg

// File: rtl/pcs_rx_align_ctrl.sv
// Multi-lane PCS receive alignment sequencer: block lock -> AM lock -> deskew -> aligned,
// with deskew timeout, cross-lane AM coincidence checking and sticky per-lane faults.
module pcs_rx_align_ctrl
  import pcs_rx_align_ctrl_pkg::*;
#(
  parameter int unsigned LANE_N          = 4,
  parameter int unsigned DESKEW_TIMEOUT  = DESKEW_TIMEOUT_DEF,
  parameter int unsigned AM_MISMATCH_MAX = AM_MISMATCH_MAX_DEF,
  parameter int unsigned CNT_W           = 8
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic [LANE_N-1:0] bs_lock_v_i,
  input  logic [LANE_N-1:0] am_lock_v_i,
  input  logic [LANE_N-1:0] am_slip_v_i,
  input  logic [LANE_N-1:0] am_v_i,
  input  logic              deskew_done_i,
  output logic              deskew_en_o,
  output logic              deskew_rst_o,
  output logic              align_status_o,
  output logic [LANE_N-1:0] lane_fault_o,
  output logic [CNT_W-1:0]  loss_cnt_o
);

  localparam int unsigned TMO_W = $clog2(DESKEW_TIMEOUT);
  localparam int unsigned MM_W  = $clog2(AM_MISMATCH_MAX + 1);

  pcs_align_state_e  state_q, state_d;
  logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic [MM_W-1:0]   mm_cnt_q, mm_cnt_d;
  logic              restart;
  logic              deskew_en_d, deskew_rst_d, align_status_d;
  logic [LANE_N-1:0] lane_fault_d;
  logic [CNT_W-1:0]  loss_cnt_d;

  logic              all_bs, all_am, lock_bad;
  logic              mm_event, mm_hit, tmo_hit;
  logic [LANE_N-1:0] lane_bad;

  // Lock/marker condition decode shared by both combinational processes
  assign all_bs   = &bs_lock_v_i;
  assign all_am   = &am_lock_v_i;
  assign lane_bad = ~bs_lock_v_i | ~am_lock_v_i | am_slip_v_i;
  assign lock_bad = |lane_bad;
  assign tmo_hit  = (tmo_cnt_q == TMO_W'(DESKEW_TIMEOUT - 1));
  assign mm_event = (|am_v_i) & ~(&am_v_i);
  assign mm_hit   = mm_event & (mm_cnt_q >= MM_W'(AM_MISMATCH_MAX - 1));

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q        <= WAIT_BS;
      tmo_cnt_q      <= '0;
      mm_cnt_q       <= '0;
      deskew_en_o    <= 1'b0;
      deskew_rst_o   <= 1'b0;
      align_status_o <= 1'b0;
      lane_fault_o   <= '0;
      loss_cnt_o     <= '0;
    end else begin
      state_q        <= state_d;
      tmo_cnt_q      <= tmo_cnt_d;
      mm_cnt_q       <= mm_cnt_d;
      deskew_en_o    <= deskew_en_d;
      deskew_rst_o   <= deskew_rst_d;
      align_status_o <= align_status_d;
      lane_fault_o   <= lane_fault_d;
      loss_cnt_o     <= loss_cnt_d;
    end
  end

  // Next-state and restart decision; lock loss outranks done and AM match
  always_comb begin
    state_d = state_q;
    restart = 1'b0;
    unique case (state_q)
      WAIT_BS: begin
        if (all_bs) state_d = WAIT_AM;
      end
      WAIT_AM: begin
        if (!all_bs)     state_d = WAIT_BS;
        else if (all_am) state_d = DESKEW;
      end
      DESKEW: begin
        if (lock_bad)                      restart = 1'b1;
        else if (deskew_done_i)            state_d = ALIGNED;
        else if (tmo_hit)                  restart = 1'b1;
      end
      ALIGNED: begin
        if (lock_bad || mm_hit) restart = 1'b1;
      end
      default: state_d = WAIT_BS;
    endcase
    if (restart) state_d = WAIT_BS;
  end

  // Next values of counters and outputs, decoded from the transition
  always_comb begin
    tmo_cnt_d      = '0;
    mm_cnt_d       = '0;
    deskew_en_d    = (state_d == DESKEW) || (state_d == ALIGNED);
    align_status_d = (state_d == ALIGNED);
    deskew_rst_d   = restart;
    lane_fault_d   = lane_fault_o;
    loss_cnt_d     = loss_cnt_o;

    if ((state_q == DESKEW) && (state_d == DESKEW)) begin
      tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
    end

    if ((state_q == ALIGNED) && (state_d == ALIGNED)) begin
      if (&am_v_i)       mm_cnt_d = '0;
      else if (mm_event) mm_cnt_d = mm_cnt_q + MM_W'(1);
      else               mm_cnt_d = mm_cnt_q;
    end

    if ((state_q == ALIGNED) && restart) begin
      lane_fault_d = lane_fault_o | lane_bad;
      loss_cnt_d   = (&loss_cnt_o) ? loss_cnt_o : loss_cnt_o + CNT_W'(1);
    end else if ((state_q != ALIGNED) && (state_d == ALIGNED)) begin
      lane_fault_d = '0;
    end
  end

endmodule : pcs_rx_align_ctrl

// File: tb/tb_pcs_rx_align_ctrl.sv
// Randomized + directed bench for pcs_rx_align_ctrl against a behavioural model.
module tb_pcs_rx_align_ctrl;

  localparam int LN  = 4;
  localparam int TMO = 16;
  localparam int MMX = 3;
  localparam int CW  = 8;
  localparam int SAT = (1 << CW) - 1;

  logic          clk;
  logic          nreset;
  logic [LN-1:0] bs, am, slip, amv;
  logic          done;
  logic          deskew_en_o, deskew_rst_o, align_status_o;
  logic [LN-1:0] lane_fault_o;
  logic [CW-1:0] loss_cnt_o;

  int n_checks = 0;
  int n_pass   = 0;
  int rst_pulses = 0;

  pcs_rx_align_ctrl #(
    .LANE_N(LN), .DESKEW_TIMEOUT(TMO), .AM_MISMATCH_MAX(MMX), .CNT_W(CW)
  ) dut (
    .clk(clk), .nreset(nreset),
    .bs_lock_v_i(bs), .am_lock_v_i(am), .am_slip_v_i(slip), .am_v_i(amv),
    .deskew_done_i(done),
    .deskew_en_o(deskew_en_o), .deskew_rst_o(deskew_rst_o),
    .align_status_o(align_status_o), .lane_fault_o(lane_fault_o),
    .loss_cnt_o(loss_cnt_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    else n_pass++;
  endtask

  // Behavioural model: phase 0 bit-lock, 1 marker-lock, 2 deskewing, 3 aligned
  int            m_phase = 0;
  int            m_in_deskew = 0;
  int            m_bad_am = 0;
  logic [LN-1:0] m_fault = '0;
  int            m_loss = 0;
  logic          e_en = 0, e_rst = 0, e_align = 0;

  task automatic model_step();
    bit lost, rs;
    int nxt;
    if (!nreset) begin
      m_phase = 0; m_in_deskew = 0; m_bad_am = 0; m_fault = '0; m_loss = 0;
      e_en = 0; e_rst = 0; e_align = 0;
      return;
    end
    lost = (bs != '1) || (am != '1) || (slip != '0);
    rs   = 0;
    nxt  = m_phase;
    if (m_phase == 0) begin
      if (bs == '1) nxt = 1;
    end else if (m_phase == 1) begin
      if (bs != '1) nxt = 0;
      else if (am == '1) nxt = 2;
    end else if (m_phase == 2) begin
      // m_in_deskew cycles already spent; this one would be number m_in_deskew+1
      if (lost) rs = 1;
      else if (done) nxt = 3;
      else if (m_in_deskew + 1 >= TMO) rs = 1;
    end else begin
      if (lost) rs = 1;
      else if (amv == '1) m_bad_am = 0;
      else if (amv != '0) begin
        m_bad_am = m_bad_am + 1;
        if (m_bad_am >= MMX) rs = 1;
      end
      if (rs) begin
        for (int i = 0; i < LN; i++)
          if (!bs[i] || !am[i] || slip[i]) m_fault[i] = 1'b1;
        if (m_loss < SAT) m_loss = m_loss + 1;
      end
    end
    if (rs) nxt = 0;
    m_in_deskew = (nxt == 2 && m_phase == 2) ? m_in_deskew + 1 : 0;
    if (nxt == 3 && m_phase != 3) m_fault = '0;
    if (nxt != 3) m_bad_am = 0;
    m_phase = nxt;
    e_rst   = rs;
    e_en    = (nxt >= 2);
    e_align = (nxt == 3);
  endtask

  // Per-cycle compare against the model, sampled just after each edge
  always @(posedge clk) begin
    model_step();
    #2;
    if (deskew_rst_o === 1'b1) rst_pulses++;
    chk("cyc_deskew_en",  32'(deskew_en_o),    32'(e_en));
    chk("cyc_deskew_rst", 32'(deskew_rst_o),   32'(e_rst));
    chk("cyc_align",      32'(align_status_o), 32'(e_align));
    chk("cyc_lane_fault", 32'(lane_fault_o),   32'(m_fault));
    chk("cyc_loss_cnt",   32'(loss_cnt_o),     32'(m_loss));
  end

  task automatic wait_align(input string nm);
    int k = 0;
    while (align_status_o !== 1'b1 && k < 60) begin @(negedge clk); k++; end
    chk(nm, 32'(align_status_o), 32'd1);
  endtask

  task automatic wait_en(input string nm);
    int k = 0;
    while (deskew_en_o !== 1'b1 && k < 60) begin @(negedge clk); k++; end
    chk(nm, 32'(deskew_en_o), 32'd1);
  endtask

  task automatic clean();
    nreset = 1; bs = '1; am = '1; slip = '0; amv = '0; done = 1;
  endtask

  initial begin
    int k;
    logic [3:0] pat [10];
    nreset = 0; bs = '1; am = '1; slip = '0; amv = '0; done = 1;
    repeat (3) @(negedge clk);
    chk("reset_align", 32'(align_status_o), 32'd0);
    chk("reset_loss",  32'(loss_cnt_o),     32'd0);
    chk("reset_en",    32'(deskew_en_o),    32'd0);

    // Clean bring-up: aligned exactly three edges after release
    nreset = 1;
    @(negedge clk); @(negedge clk);
    chk("bringup_edge2_align", 32'(align_status_o), 32'd0);
    @(negedge clk);
    chk("bringup_edge3_align", 32'(align_status_o), 32'd1);
    chk("bringup_loss", 32'(loss_cnt_o), 32'd0);
    chk("bringup_no_rst", 32'(rst_pulses), 32'd0);

    // Lane fault via slip on lane 2, then deskew timeout with done held low
    done = 0; slip = 4'b0100;
    @(negedge clk); slip = '0;
    chk("fault_set",   32'(lane_fault_o),   32'h4);
    chk("fault_rst",   32'(deskew_rst_o),   32'd1);
    chk("fault_align", 32'(align_status_o), 32'd0);
    chk("fault_loss",  32'(loss_cnt_o),     32'd1);
    @(negedge clk);
    chk("rst_single_cycle", 32'(deskew_rst_o), 32'd0);
    wait_en("timeout_enter_deskew");
    k = 0;
    while (deskew_rst_o !== 1'b1 && k < 100) begin @(negedge clk); k++; end
    chk("timeout_cycles", 32'(k), 32'd16);
    chk("fault_sticky", 32'(lane_fault_o), 32'h4);
    @(negedge clk);
    chk("timeout_rst_one_cycle", 32'(deskew_rst_o), 32'd0);
    wait_en("timeout_reenter_deskew");
    done = 1;
    wait_align("fault_reacquire");
    chk("fault_cleared", 32'(lane_fault_o), 32'h0);

    // AM mismatch: an all-lane AM in between resets the count
    pat = '{4'hB, 4'h0, 4'hB, 4'h0, 4'hF, 4'h0, 4'hB, 4'h0, 4'hB, 4'h0};
    for (int i = 0; i < 10; i++) begin amv = pat[i]; @(negedge clk); end
    chk("mm_match_resets", 32'(align_status_o), 32'd1);
    amv = 4'hB; done = 0;
    @(negedge clk); amv = '0;
    chk("mm_drop_align", 32'(align_status_o), 32'd0);
    chk("mm_drop_rst",   32'(deskew_rst_o),   32'd1);
    chk("mm_drop_loss",  32'(loss_cnt_o),     32'd2);
    chk("mm_drop_fault", 32'(lane_fault_o),   32'h0);

    // done rising together with lane-0 lock loss: restart wins
    wait_en("simul_enter_deskew");
    done = 1; bs = 4'b1110;
    @(negedge clk); bs = '1;
    chk("simul_align", 32'(align_status_o), 32'd0);
    chk("simul_rst",   32'(deskew_rst_o),   32'd1);
    chk("simul_loss",  32'(loss_cnt_o),     32'd2);
    wait_align("simul_recover");

    // Randomized phase with slowly varying done and rare resets
    for (int c = 0; c < 3000; c++) begin
      nreset = ($urandom_range(0, 199) != 0);
      bs   = ($urandom_range(0, 24) == 0) ? 4'($urandom) : 4'hF;
      am   = ($urandom_range(0, 24) == 0) ? 4'($urandom) : 4'hF;
      slip = ($urandom_range(0, 39) == 0) ? 4'($urandom) : 4'h0;
      k    = $urandom_range(0, 9);
      amv  = (k < 6) ? 4'h0 : (k < 8) ? 4'hF : 4'($urandom);
      if ($urandom_range(0, 9) == 0) done = ~done;
      @(negedge clk);
    end

    // Loss counter saturation
    clean();
    for (int n = 0; n < SAT + 5; n++) begin
      wait_align("sat_align");
      slip = 4'b0001;
      @(negedge clk); slip = '0;
    end
    chk("sat_loss", 32'(loss_cnt_o), 32'd255);

    // Reset while aligned: everything clears, no restart pulse
    wait_align("pre_reset_align");
    nreset = 0;
    @(negedge clk); nreset = 1;
    chk("midrst_align", 32'(align_status_o), 32'd0);
    chk("midrst_rst",   32'(deskew_rst_o),   32'd0);
    chk("midrst_loss",  32'(loss_cnt_o),     32'd0);
    chk("midrst_fault", 32'(lane_fault_o),   32'h0);
    chk("midrst_en",    32'(deskew_en_o),    32'd0);
    @(negedge clk);
    chk("midrst_no_pulse", 32'(deskew_rst_o), 32'd0);
    wait_align("post_reset_align");

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_pcs_rx_align_ctrl
